// File: rtl/wb_unit_if.sv
// Writeback unit handshake bundle.
// ALU result and load return ports with valid/ready.
interface wb_unit_if;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_valid;
  logic [4:0]  i_ld_rd;
  logic [31:0] i_ld_rdata;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_addr_lo;
  logic        o_ld_ready;

  modport master (
    output i_alu_valid, i_alu_rd, i_alu_data,
    output i_ld_valid, i_ld_rd, i_ld_rdata,
    output i_ld_funct3, i_ld_addr_lo,
    input  o_alu_ready, o_ld_ready
  );

  modport slave (
    input  i_alu_valid, i_alu_rd, i_alu_data,
    input  i_ld_valid, i_ld_rd, i_ld_rdata,
    input  i_ld_funct3, i_ld_addr_lo,
    output o_alu_ready, o_ld_ready
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback arbiter: ALU results vs buffered load returns,
// load data formatting, and outstanding-load scoreboard.
module wb_unit #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_unit_if.slave    bus,
  input  logic        i_issue_ld_valid,
  input  logic [4:0]  i_issue_ld_rd,
  output logic        o_wr,
  output logic [4:0]  o_rd,
  output logic [31:0] o_write_data,
  output logic [31:0] o_pending,
  output logic        o_ld_err
);

  localparam int SW =
    (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [1:0]  lo;
  } ld_ent_t;

  ld_ent_t       mem_q [2];
  logic          wp_q, wp_d;
  logic          rp_q, rp_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   data_q, data_d;

  logic          empty, starving;
  logic          ld_ready, alu_ready;
  logic          push, pop, alu_xfer;
  ld_ent_t       head;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   fmt_data;
  logic          fmt_err;

  assign empty    = (cnt_q == 2'd0);
  assign starving = (starve_q == SMAX)
                  && bus.i_alu_valid;
  assign ld_ready  = rst_n && (cnt_q != 2'd2);
  assign alu_ready = rst_n && (empty || starving);
  assign bus.o_ld_ready  = ld_ready;
  assign bus.o_alu_ready = alu_ready;

  assign push     = bus.i_ld_valid && ld_ready;
  assign pop      = !empty && !starving;
  assign alu_xfer = bus.i_alu_valid && alu_ready;
  assign head     = mem_q[rp_q];

  assign byte_v = head.data[{head.lo, 3'b000} +: 8];
  assign half_v = head.lo[1] ? head.data[31:16]
                             : head.data[15:0];

  // Shape the FIFO head into a register value, flag bad loads.
  always_comb begin
    fmt_data = '0;
    fmt_err  = 1'b0;
    case (head.f3)
      3'b000: fmt_data = {{24{byte_v[7]}}, byte_v};
      3'b001: begin
        fmt_data = {{16{half_v[15]}}, half_v};
        fmt_err  = head.lo[0];
      end
      3'b010: begin
        fmt_data = head.data;
        fmt_err  = |head.lo;
      end
      3'b100: fmt_data = {24'h0, byte_v};
      3'b101: begin
        fmt_data = {16'h0, half_v};
        fmt_err  = head.lo[0];
      end
      default: fmt_err = 1'b1;
    endcase
  end

  // Pick the writeback source and compute all next state.
  always_comb begin
    wr_d     = 1'b0;
    err_d    = 1'b0;
    rd_d     = rd_q;
    data_d   = data_q;
    starve_d = starve_q;
    pend_d   = pend_q;
    wp_d     = wp_q ^ push;
    rp_d     = rp_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    unique case (1'b1)
      pop: begin
        err_d = fmt_err;
        wr_d  = !fmt_err && (head.rd != 5'd0);
        if (!fmt_err) begin
          rd_d   = head.rd;
          data_d = fmt_data;
        end
        pend_d[head.rd] = 1'b0;
      end
      alu_xfer: begin
        wr_d   = bus.i_alu_rd != 5'd0;
        rd_d   = bus.i_alu_rd;
        data_d = bus.i_alu_data;
      end
      default: ;
    endcase
    if (!bus.i_alu_valid || alu_xfer)
      starve_d = '0;
    else if (pop && starve_q != SMAX)
      starve_d = starve_q + SW'(1);
    if (i_issue_ld_valid && i_issue_ld_rd != 5'd0)
      pend_d[i_issue_ld_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // State and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
      starve_q <= '0;
      pend_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 5'd0;
      data_q   <= 32'd0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  // Load return storage, written on accepted pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= '{
        rd:   bus.i_ld_rd,
        data: bus.i_ld_rdata,
        f3:   bus.i_ld_funct3,
        lo:   bus.i_ld_addr_lo
      };
    end
  end

  assign o_wr         = wr_q;
  assign o_rd         = rd_q;
  assign o_write_data = data_q;
  assign o_pending    = pend_q;
  assign o_ld_err     = err_q;

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive load writebacks while an ALU result waits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ALU result port i_alu_valid/i_alu_rd[4:0]/i_alu_data[31:0] (inputs) and o_alu_ready (output, 1).
REQ-005 SHALL have load return port i_ld_valid, i_ld_rd[4:0], i_ld_rdata[31:0], i_ld_funct3[2:0], i_ld_addr_lo[1:0] (inputs) and o_ld_ready (output, 1).
REQ-006 SHALL have load issue port i_issue_ld_valid (1) and i_issue_ld_rd[4:0], both inputs, marking a load destination pending.
REQ-007 SHALL have register file write port o_wr (1), o_rd (5), o_write_data (32), all outputs, driven from registers.
REQ-008 SHALL have o_pending, output, 32, per-register outstanding-load scoreboard; bit 0 constantly 0.
REQ-009 SHALL have o_ld_err, output, 1, one-cycle pulse on an illegal or misaligned load return.

Function
REQ-010 SHALL transfer on either input port only when valid and ready are both high at a rising edge.
REQ-011 SHALL buffer load returns in a 2-entry FIFO; o_ld_ready = (FIFO count < 2), with no push-side dependence on the same-cycle pop.
REQ-012 SHALL, each cycle, select exactly one writeback source: FIFO head if non-empty and not starving, else the ALU port.
REQ-013 SHALL define starving = (starve_cnt == STARVE_MAX) and i_alu_valid.
REQ-014 SHALL drive o_alu_ready combinationally = (FIFO empty) or starving.
REQ-015 SHALL increment starve_cnt (saturating at STARVE_MAX) on each FIFO pop while i_alu_valid is high.
REQ-016 SHALL clear starve_cnt on an ALU transfer or whenever i_alu_valid is low.
REQ-017 SHALL register the selected result: an ALU transfer at edge N gives o_wr=1 in cycle N+1 (latency 1).
REQ-018 SHALL give loads latency 2: push at edge N, pop at edge N+1 if selected, o_wr=1 in cycle N+2.
REQ-019 SHALL drop o_wr to 0 in any cycle following an edge where nothing was popped or accepted.
REQ-020 SHALL format load data by funct3 and addr_lo as LB 000 sign-extended byte, LH 001 sign-extended half, LW 010 word, LBU 100 zero-extended byte, LHU 101 zero-extended half.
REQ-021 SHALL take byte lane = addr_lo and halfword lane = addr_lo[1].
REQ-022 SHALL treat as error: funct3 in {011,110,111}; LH/LHU with addr_lo[0]=1; LW with addr_lo!=0.
REQ-023 SHALL, on an error entry being popped, keep o_wr=0 next cycle, pulse o_ld_err for that cycle, and still clear its pending bit.
REQ-024 SHALL consume any result with rd=0 normally but never assert o_wr for it.
REQ-025 SHALL set o_pending[i_issue_ld_rd] at the edge when i_issue_ld_valid=1 and rd!=0.
REQ-026 SHALL clear o_pending[rd] at the edge a load entry for rd is popped.
REQ-027 SHALL let set win over clear when both target the same rd in the same cycle.
REQ-028 SHALL keep ALU writebacks from affecting o_pending.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronously, independent of clk), force o_wr=0, o_rd=0, o_write_data=0, o_ld_err=0, o_pending=0, FIFO empty, starve_cnt=0.
REQ-030 SHALL, during reset, drive o_ld_ready=0 and o_alu_ready=0.
REQ-031 SHALL resume normal operation on the first rising edge after rst_n rises.
REQ-032 SHALL discard in-flight FIFO entries and the pending scoreboard on reset mid-operation.

Verification
REQ-033 SHALL cover: ALU valid, rd=5, data 0xDEADBEEF, FIFO empty -> o_wr=1, o_rd=5, o_write_data=0xDEADBEEF exactly one cycle later.
REQ-034 SHALL cover: LB with rdata 0x12345680, addr_lo=0, rd=7 -> o_write_data=0xFFFFFF80 two cycles later; same return as LBU -> 0x00000080.
REQ-035 SHALL cover: LW with addr_lo=2 -> o_ld_err pulse, o_wr stays 0, pending bit cleared.
REQ-036 SHALL cover: continuous loads with ALU valid (STARVE_MAX=4) -> four load writes, then one ALU write, then loads resume.
REQ-037 SHALL cover: issue rd=3 and pop load rd=3 in the same cycle -> o_pending[3] remains 1.
REQ-038 SHALL cover: rst_n low mid-stream with FIFO full -> outputs 0 immediately; no writes from stale entries after release.
